rr_arbiter_4: RTL and testbench

- Round-robin arbiter that shares one 4-way resource among four requesters.
- Registers a 2-bit grant index plus a grant enable, then drives a decoder_2_to_4 instance to produce the one-hot grant vector.
- A grant is held while its requester keeps requesting, with an optional hold-time limit.
- Used wherever the design multiplexes a shared bus, row driver or memory port across four clients.

---
 rtl/rr_arbiter_4.sv | 117 +++++++++++
 tb/tb_rr_arbiter_4.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_4.sv
// Four-way round-robin arbiter with grant hold and an optional hold-time limit.
// The one-hot grant vector is decoded from the registered grant index/enable.

module decoder_2_to_4 (
  input  logic       ena_i,
  input  logic [1:0] idx_i,
  output logic [3:0] dec_o
);

  always_comb begin
    dec_o = 4'b0000;
    if (ena_i) dec_o[idx_i] = 1'b1;
  end

endmodule

module rr_arbiter_4 #(
  parameter int MAX_HOLD = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic       gnt_ena,
  output logic [1:0] gnt_idx,
  output logic [3:0] gnt,
  output logic       busy,
  output logic       timeout
);

  localparam int HW     = (MAX_HOLD > 0 && $clog2(MAX_HOLD + 1) > 1) ? $clog2(MAX_HOLD + 1) : 1;
  localparam int LIMIT  = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;
  localparam bit LIMITED = (MAX_HOLD > 0);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [1:0]    idx_q, idx_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          timeout_q, timeout_d;

  logic          win_found;
  logic [1:0]    win_idx;

  // Scan requesters starting at ptr; the first one set wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    for (int k = 0; k < 4; k++) begin
      if (!win_found && req[ptr_q + 2'(k)]) begin
        win_found = 1'b1;
        win_idx   = ptr_q + 2'(k);
      end
    end
  end

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = GRANT;
          idx_d   = win_idx;
          hold_d  = '0;
        end
      end
      default: begin
        if (!req[idx_q]) begin
          state_d = IDLE;
          ptr_d   = idx_q + 2'd1;
        end else if (LIMITED && hold_q == HW'(LIMIT)) begin
          state_d   = IDLE;
          ptr_d     = idx_q + 2'd1;
          timeout_d = 1'b1;
        end else if (LIMITED) begin
          hold_d = hold_q + HW'(1);
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples the pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= 2'd0;
      idx_q     <= 2'd0;
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  // Grant enable and busy both mean "in GRANT"; the state bit is their register.
  assign gnt_ena = (state_q == GRANT);
  assign busy    = (state_q == GRANT);
  assign gnt_idx = idx_q;
  assign timeout = timeout_q;

  decoder_2_to_4 u_dec (
    .ena_i (gnt_ena),
    .idx_i (idx_q),
    .dec_o (gnt)
  );

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Directed bench for rr_arbiter_4: three instances cover MAX_HOLD = 0, 4 and 2.

module tb_rr_arbiter_4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req0 = 4'b0, req4 = 4'b0, req2 = 4'b0;

  logic       gnt_ena0, busy0, timeout0;
  logic       gnt_ena4, busy4, timeout4;
  logic       gnt_ena2, busy2, timeout2;
  logic [1:0] gnt_idx0, gnt_idx4, gnt_idx2;
  logic [3:0] gnt0, gnt4, gnt2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rr_arbiter_4 #(.MAX_HOLD(0)) dut0 (
    .clk(clk), .rst(rst), .req(req0), .gnt_ena(gnt_ena0), .gnt_idx(gnt_idx0),
    .gnt(gnt0), .busy(busy0), .timeout(timeout0));
  rr_arbiter_4 #(.MAX_HOLD(4)) dut4 (
    .clk(clk), .rst(rst), .req(req4), .gnt_ena(gnt_ena4), .gnt_idx(gnt_idx4),
    .gnt(gnt4), .busy(busy4), .timeout(timeout4));
  rr_arbiter_4 #(.MAX_HOLD(2)) dut2 (
    .clk(clk), .rst(rst), .req(req2), .gnt_ena(gnt_ena2), .gnt_idx(gnt_idx2),
    .gnt(gnt2), .busy(busy2), .timeout(timeout2));

  // Observed status packed as {gnt_ena, gnt, busy, timeout}.
  wire [6:0] obs0 = {gnt_ena0, gnt0, busy0, timeout0};
  wire [6:0] obs4 = {gnt_ena4, gnt4, busy4, timeout4};
  wire [6:0] obs2 = {gnt_ena2, gnt2, busy2, timeout2};

  function automatic logic [6:0] granted(input logic [1:0] idx);
    logic [3:0] oh;
    oh = 4'b0001 << idx;
    return {1'b1, oh, 1'b1, 1'b0};
  endfunction

  function automatic logic [6:0] idle(input logic to);
    return {1'b0, 4'b0000, 1'b0, to};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_all();
    req0 = 4'b0; req4 = 4'b0; req2 = 4'b0;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    checks++;
    if (obs0 !== idle(1'b0) || gnt_idx0 !== 2'd0) begin
      errors++; $display("FAIL reset_power_on: got %b idx %0d, want %b idx 0", obs0, gnt_idx0, idle(1'b0));
    end
    rst = 1'b0;
    req0 = 4'b0100;
    step();
    checks++;
    if (obs0 !== granted(2'd2) || gnt_idx0 !== 2'd2) begin
      errors++; $display("FAIL reset_pre_grant: got %b idx %0d, want %b idx 2", obs0, gnt_idx0, granted(2'd2));
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (obs0 !== idle(1'b0) || gnt_idx0 !== 2'd0) begin
      errors++; $display("FAIL reset_async: got %b idx %0d, want %b idx 0", obs0, gnt_idx0, idle(1'b0));
    end
    req0 = 4'b0000;
    #3 rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      checks++;
      if (obs0 !== idle(1'b0)) begin
        errors++; $display("FAIL reset_idle_c%0d: got %b, want %b", c, obs0, idle(1'b0));
      end
    end
  endtask

  task automatic test_single();
    reset_all();
    req0 = 4'b0100;
    step();
    checks++;
    if (obs0 !== granted(2'd2) || gnt_idx0 !== 2'd2) begin
      errors++; $display("FAIL single_grant2: got %b idx %0d, want %b idx 2", obs0, gnt_idx0, granted(2'd2));
    end
    req0 = 4'b0000;
    step();
    checks++;
    if (obs0 !== idle(1'b0)) begin
      errors++; $display("FAIL single_release: got %b, want %b", obs0, idle(1'b0));
    end
    req0 = 4'b0001;
    step();
    checks++;
    if (obs0 !== granted(2'd0) || gnt_idx0 !== 2'd0) begin
      errors++; $display("FAIL single_wrap0: got %b idx %0d, want %b idx 0", obs0, gnt_idx0, granted(2'd0));
    end
    req0 = 4'b0000;
    step();
  endtask

  task automatic test_rotation();
    logic [1:0] exp_idx;
    reset_all();
    req0 = 4'b1111;
    step();
    for (int i = 0; i < 5; i++) begin
      exp_idx = 2'(i % 4);
      for (int c = 0; c < 3; c++) begin
        checks++;
        if (obs0 !== granted(exp_idx) || gnt_idx0 !== exp_idx) begin
          errors++; $display("FAIL rotation_g%0d_c%0d: got %b idx %0d, want %b idx %0d",
                             i, c, obs0, gnt_idx0, granted(exp_idx), exp_idx);
        end
        if (c < 2) step();
      end
      req0[exp_idx] = 1'b0;
      step();
      checks++;
      if (obs0 !== idle(1'b0)) begin
        errors++; $display("FAIL rotation_gap%0d: got %b, want %b", i, obs0, idle(1'b0));
      end
      req0[exp_idx] = 1'b1;
      step();
    end
    req0 = 4'b0000;
    step();
  endtask

  task automatic test_timeout();
    logic [1:0] exp_idx;
    reset_all();
    req4 = 4'b0011;
    step();
    for (int g = 0; g < 2; g++) begin
      exp_idx = 2'(g);
      for (int c = 0; c < 4; c++) begin
        checks++;
        if (obs4 !== granted(exp_idx) || gnt_idx4 !== exp_idx) begin
          errors++; $display("FAIL timeout_g%0d_c%0d: got %b idx %0d, want %b idx %0d",
                             g, c, obs4, gnt_idx4, granted(exp_idx), exp_idx);
        end
        step();
      end
      checks++;
      if (obs4 !== idle(1'b1)) begin
        errors++; $display("FAIL timeout_pulse%0d: got %b, want %b", g, obs4, idle(1'b1));
      end
      step();
    end
    checks++;
    if (obs4 !== granted(2'd0) || gnt_idx4 !== 2'd0) begin
      errors++; $display("FAIL timeout_back_to_0: got %b idx %0d, want %b idx 0", obs4, gnt_idx4, granted(2'd0));
    end
    req4 = 4'b0000;
    step();
    checks++;
    if (obs4 !== idle(1'b0)) begin
      errors++; $display("FAIL timeout_normal_release: got %b, want %b", obs4, idle(1'b0));
    end
  endtask

  task automatic test_simultaneous();
    reset_all();
    req2 = 4'b0001;
    step();
    step();
    checks++;
    if (obs2 !== granted(2'd0) || gnt_idx2 !== 2'd0) begin
      errors++; $display("FAIL simul_held: got %b idx %0d, want %b idx 0", obs2, gnt_idx2, granted(2'd0));
    end
    req2 = 4'b0000;
    step();
    checks++;
    if (obs2 !== idle(1'b0)) begin
      errors++; $display("FAIL simul_no_timeout: got %b, want %b", obs2, idle(1'b0));
    end
    req2 = 4'b0011;
    step();
    checks++;
    if (obs2 !== granted(2'd1) || gnt_idx2 !== 2'd1) begin
      errors++; $display("FAIL simul_ptr1: got %b idx %0d, want %b idx 1", obs2, gnt_idx2, granted(2'd1));
    end
    req2 = 4'b0000;
    step();
  endtask

  task automatic test_priority_wrap();
    reset_all();
    req0 = 4'b0100;
    step();
    req0 = 4'b0000;
    step();
    req0 = 4'b1001;
    step();
    checks++;
    if (obs0 !== granted(2'd3) || gnt_idx0 !== 2'd3) begin
      errors++; $display("FAIL wrap_idx3: got %b idx %0d, want %b idx 3", obs0, gnt_idx0, granted(2'd3));
    end
    req0 = 4'b0001;
    step();
    checks++;
    if (obs0 !== idle(1'b0)) begin
      errors++; $display("FAIL wrap_release: got %b, want %b", obs0, idle(1'b0));
    end
    req0 = 4'b1001;
    step();
    checks++;
    if (obs0 !== granted(2'd0) || gnt_idx0 !== 2'd0) begin
      errors++; $display("FAIL wrap_idx0: got %b idx %0d, want %b idx 0", obs0, gnt_idx0, granted(2'd0));
    end
    req0 = 4'b0000;
    step();
  endtask

  initial begin
    #2;
    test_reset();
    test_single();
    test_rotation();
    test_timeout();
    test_simultaneous();
    test_priority_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
